// File: rtl/java_cpu_timer.sv
// java_cpu_timer: memory-mapped down-counting timer on the java_cpu bus.
// Optional capture input enabled with `define TIMER_CAPTURE_EN.
module java_cpu_timer #(
  parameter int WIDTH     = 32,
  parameter int ADDR_BITS = 3
) (
  input  logic        clk,
  input  logic        nreset,
  input  logic        mem_valid,
  input  logic        mem_nwr,
  input  logic [31:0] mem_address,
  input  logic [31:0] mem_data_in,
  output logic [31:0] mem_data_out,
  output logic        mem_ready,
  output logic        interrupt,
  input  logic        interrupt_ack
`ifdef TIMER_CAPTURE_EN
  ,
  input  logic        capture_in
`endif
);

  logic [ADDR_BITS-1:0] sel;
  logic                 access;
  logic                 wr;
  logic                 rd;
  logic                 s_ctrl;
  logic                 s_pre;
  logic                 s_rel;
  logic                 s_cnt;
  logic                 s_stat;
  logic                 s_cap;
  logic [WIDTH-1:0]     wdat;

  logic             en;
  logic             ie;
  logic             auto_r;
  logic [WIDTH-1:0] prescale;
  logic [WIDTH-1:0] reload;
  logic [WIDTH-1:0] count;
  logic [WIDTH-1:0] pcnt;
  logic             pend;
  logic             capf;
  logic             tick;
  logic             expire;
  logic [31:0]      rdata;
  logic             unused_bits;

  assign sel    = mem_address[ADDR_BITS-1:0];
  assign access = mem_valid & ~mem_ready;
  assign wr     = access & ~mem_nwr;
  assign rd     = access & mem_nwr;
  assign wdat   = mem_data_in[WIDTH-1:0];

  assign s_ctrl = sel == ADDR_BITS'(0);
  assign s_pre  = sel == ADDR_BITS'(1);
  assign s_rel  = sel == ADDR_BITS'(2);
  assign s_cnt  = sel == ADDR_BITS'(3);
  assign s_stat = sel == ADDR_BITS'(4);
  assign s_cap  = sel == ADDR_BITS'(5);

  assign unused_bits = ^{mem_address, mem_data_in, s_cap};

  assign tick   = en & (pcnt == prescale);
  assign expire = tick & (count == '0);

  assign interrupt = pend & ie;

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      mem_ready    <= 1'b0;
      mem_data_out <= '0;
    end else begin
      mem_ready <= mem_valid;
      if (rd)
        mem_data_out <= rdata;
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      en       <= 1'b0;
      ie       <= 1'b0;
      auto_r   <= 1'b0;
      prescale <= '0;
      reload   <= '0;
    end else begin
      // CPU write beats the one-shot clear of EN
      if (wr && s_ctrl) begin
        en     <= mem_data_in[0];
        ie     <= mem_data_in[1];
        auto_r <= mem_data_in[2];
      end else if (expire && !auto_r) begin
        en <= 1'b0;
      end
      if (wr && s_pre)
        prescale <= wdat;
      if (wr && s_rel)
        reload <= wdat;
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      pcnt <= '0;
    end else if (wr && (s_cnt || s_pre)) begin
      pcnt <= '0;
    end else if (!en || tick) begin
      pcnt <= '0;
    end else begin
      pcnt <= pcnt + WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      count <= '0;
    end else if (wr && s_cnt) begin
      count <= wdat;
    end else if (tick) begin
      if (count != '0)
        count <= count - WIDTH'(1);
      else if (auto_r)
        count <= reload;
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      pend <= 1'b0;
    end else if (expire) begin
      pend <= 1'b1;
    end else if (interrupt_ack || (wr && s_stat && mem_data_in[0])) begin
      pend <= 1'b0;
    end
  end

`ifdef TIMER_CAPTURE_EN
  logic [2:0]       cap_sync;
  logic             cap_rise;
  logic [WIDTH-1:0] capture;

  // [1] is the synchronised level, [2] its previous value
  assign cap_rise = cap_sync[1] & ~cap_sync[2];

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      cap_sync <= '0;
      capture  <= '0;
      capf     <= 1'b0;
    end else begin
      cap_sync <= {cap_sync[1:0], capture_in};
      if (cap_rise) begin
        capture <= count;
        capf    <= 1'b1;
      end else if (wr && s_stat && mem_data_in[1]) begin
        capf <= 1'b0;
      end
    end
  end
`else
  assign capf = 1'b0;
`endif

  always_comb begin
    rdata = '0;
    unique case (1'b1)
      s_ctrl: rdata[2:0] = {auto_r, ie, en};
      s_pre:  rdata[WIDTH-1:0] = prescale;
      s_rel:  rdata[WIDTH-1:0] = reload;
      s_cnt:  rdata[WIDTH-1:0] = count;
      s_stat: rdata[1:0] = {capf, pend};
`ifdef TIMER_CAPTURE_EN
      s_cap:  rdata[WIDTH-1:0] = capture;
`endif
      default: rdata = '0;
    endcase
  end

endmodule

// File: tb/tb_java_cpu_timer.sv
// tb_java_cpu_timer: directed self-checking bench for java_cpu_timer.
// Capture steps run only when TIMER_CAPTURE_EN is defined.
module tb_java_cpu_timer;

  logic        clk = 1'b0;
  logic        nreset;
  logic        mem_valid;
  logic        mem_nwr;
  logic [31:0] mem_address;
  logic [31:0] mem_data_in;
  logic [31:0] mem_data_out;
  logic        mem_ready;
  logic        interrupt;
  logic        interrupt_ack;
`ifdef TIMER_CAPTURE_EN
  logic        capture_in;
`endif

  int checks   = 0;
  int failures = 0;
  logic [31:0] d;

  always #5 clk = ~clk;

  java_cpu_timer dut (
    .clk           (clk),
    .nreset        (nreset),
    .mem_valid     (mem_valid),
    .mem_nwr       (mem_nwr),
    .mem_address   (mem_address),
    .mem_data_in   (mem_data_in),
    .mem_data_out  (mem_data_out),
    .mem_ready     (mem_ready),
    .interrupt     (interrupt),
    .interrupt_ack (interrupt_ack)
`ifdef TIMER_CAPTURE_EN
    ,
    .capture_in    (capture_in)
`endif
  );

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Access lands on the second posedge after the call; returns 1ns after it
  task automatic wr(input logic [31:0] a, input logic [31:0] v);
    @(negedge clk);
    @(negedge clk);
    mem_valid   = 1'b1;
    mem_nwr     = 1'b0;
    mem_address = a;
    mem_data_in = v;
    @(posedge clk);
    #1;
    mem_valid = 1'b0;
    mem_nwr   = 1'b1;
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] v);
    @(negedge clk);
    @(negedge clk);
    mem_valid   = 1'b1;
    mem_nwr     = 1'b1;
    mem_address = a;
    @(posedge clk);
    #1;
    v = mem_data_out;
    mem_valid = 1'b0;
  endtask

  initial begin
    nreset        = 1'b1;
    mem_valid     = 1'b0;
    mem_nwr       = 1'b1;
    mem_address   = '0;
    mem_data_in   = '0;
    interrupt_ack = 1'b0;
`ifdef TIMER_CAPTURE_EN
    capture_in    = 1'b0;
`endif
    #1 nreset = 1'b0;
    #2;
    check("rst_ready", {31'd0, mem_ready}, 32'd0);
    check("rst_dout", mem_data_out, 32'd0);
    check("rst_irq", {31'd0, interrupt}, 32'd0);
    @(negedge clk);
    nreset = 1'b1;

    // held-valid write: one access only
    @(negedge clk);
    mem_valid   = 1'b1;
    mem_nwr     = 1'b0;
    mem_address = 32'd2;
    mem_data_in = 32'h1234;
    #1 check("bus_ready_lo", {31'd0, mem_ready}, 32'd0);
    @(posedge clk);
    #1 check("bus_ready_1", {31'd0, mem_ready}, 32'd1);
    mem_data_in = 32'h5555;
    @(posedge clk);
    #1 check("bus_ready_2", {31'd0, mem_ready}, 32'd1);
    @(posedge clk);
    #1 check("bus_ready_3", {31'd0, mem_ready}, 32'd1);
    mem_valid = 1'b0;
    mem_nwr   = 1'b1;
    @(posedge clk);
    #1 check("bus_ready_drop", {31'd0, mem_ready}, 32'd0);
    rd(32'd2, d);
    check("reload_rd", d, 32'h1234);
    repeat (3) @(posedge clk);
    #1 check("dout_hold", mem_data_out, 32'h1234);
    rd(32'd6, d);
    check("off6_rd", d, 32'd0);

    // periodic: period 8 cycles
    wr(32'd1, 32'd1);
    wr(32'd2, 32'd3);
    wr(32'd3, 32'd3);
    wr(32'd0, 32'd7);
    repeat (7) @(posedge clk);
    #1 check("per_pre", {31'd0, interrupt}, 32'd0);
    @(posedge clk);
    #1 check("per_first", {31'd0, interrupt}, 32'd1);
    interrupt_ack = 1'b1;
    @(posedge clk);
    #1 interrupt_ack = 1'b0;
    check("per_ack", {31'd0, interrupt}, 32'd0);
    repeat (6) @(posedge clk);
    #1 check("per_pre2", {31'd0, interrupt}, 32'd0);
    @(posedge clk);
    #1 check("per_second", {31'd0, interrupt}, 32'd1);
    wr(32'd0, 32'd0);
    wr(32'd4, 32'd1);
    check("per_stop", {31'd0, interrupt}, 32'd0);

    // one-shot
    wr(32'd1, 32'd0);
    wr(32'd3, 32'd2);
    wr(32'd0, 32'd3);
    repeat (2) @(posedge clk);
    #1 check("os_pre", {31'd0, interrupt}, 32'd0);
    @(posedge clk);
    #1 check("os_fire", {31'd0, interrupt}, 32'd1);
    rd(32'd0, d);
    check("os_ctrl", d, 32'd2);
    rd(32'd3, d);
    check("os_count", d, 32'd0);
    wr(32'd4, 32'd1);
    repeat (10) @(posedge clk);
    #1 check("os_quiet", {31'd0, interrupt}, 32'd0);

    // masking
    wr(32'd3, 32'd1);
    wr(32'd0, 32'd1);
    repeat (4) @(posedge clk);
    #1 check("mask_irq", {31'd0, interrupt}, 32'd0);
    rd(32'd4, d);
    check("mask_pend", d, 32'd1);
    wr(32'd0, 32'd2);
    check("unmask_irq", {31'd0, interrupt}, 32'd1);
    wr(32'd4, 32'd1);
    check("w1c_irq", {31'd0, interrupt}, 32'd0);

    // STATUS clear on the expiry edge: set wins
    wr(32'd3, 32'd1);
    wr(32'd0, 32'd3);
    wr(32'd4, 32'd1);
    check("race_irq", {31'd0, interrupt}, 32'd1);
    rd(32'd4, d);
    check("race_pend", d, 32'd1);
    wr(32'd4, 32'd1);

    // CTRL write on the one-shot expiry edge wins
    wr(32'd3, 32'd1);
    wr(32'd0, 32'd1);
    wr(32'd0, 32'd5);
    rd(32'd0, d);
    check("ctrl_race", d, 32'd5);
    wr(32'd0, 32'd0);
    wr(32'd4, 32'd1);

    // COUNT write on a tick edge wins
    wr(32'd3, 32'd5);
    wr(32'd0, 32'd5);
    wr(32'd3, 32'd100);
    rd(32'd3, d);
    check("count_race", d, 32'd99);
    wr(32'd0, 32'd0);
    wr(32'd4, 32'd1);

    // reset mid-access while counting
    wr(32'd1, 32'd0);
    wr(32'd2, 32'd3);
    wr(32'd3, 32'd3);
    wr(32'd0, 32'd7);
    repeat (5) @(posedge clk);
    #1 check("mr_irq_pre", {31'd0, interrupt}, 32'd1);
    @(negedge clk);
    mem_valid   = 1'b1;
    mem_nwr     = 1'b1;
    mem_address = 32'd0;
    @(posedge clk);
    #1 check("mr_ready_pre", {31'd0, mem_ready}, 32'd1);
    check("mr_dout_pre", mem_data_out, 32'd7);
    #2 nreset = 1'b0;
    #1;
    check("mr_ready", {31'd0, mem_ready}, 32'd0);
    check("mr_dout", mem_data_out, 32'd0);
    check("mr_irq", {31'd0, interrupt}, 32'd0);
    @(negedge clk);
    mem_valid = 1'b0;
    @(negedge clk);
    nreset = 1'b1;
    repeat (3) @(posedge clk);
    rd(32'd0, d);
    check("mr_ctrl", d, 32'd0);
    check("mr_irq_post", {31'd0, interrupt}, 32'd0);

`ifdef TIMER_CAPTURE_EN
    wr(32'd1, 32'd1000);
    wr(32'd3, 32'd5);
    wr(32'd0, 32'd1);
    @(negedge clk);
    capture_in = 1'b1;
    repeat (4) @(posedge clk);
    rd(32'd5, d);
    check("cap_value", d, 32'd5);
    rd(32'd4, d);
    check("cap_status", d, 32'd2);
    check("cap_irq", {31'd0, interrupt}, 32'd0);
    wr(32'd0, 32'd0);
`else
    rd(32'd5, d);
    check("cap_absent", d, 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/java_cpu_timer.md
Name: java_cpu_timer

Overview:
- Memory-mapped down-counting timer that sits on the java_cpu memory bus next to the data RAM.
- Drives one bit of the CPU interrupt vector and consumes the matching interrupt_ack.
- Gives test programs a periodic or one-shot tick and exercises the CPU interrupt path.
- Responds with the same valid/ready single-access handshake as the RAM. An external decoder gates mem_valid by address.

Parameters:
- WIDTH, 32, width of the counter, reload and prescaler registers (max 32).
- ADDR_BITS, 3, number of low mem_address bits used to select a register.

Ports:
- clk  in  1  system clock
- nreset  in  1  asynchronous active-low reset
- mem_valid  in  1  access request, already qualified by the external address decode
- mem_nwr  in  1  0 = write, 1 = read
- mem_address  in  32  word address; only [ADDR_BITS-1:0] is used
- mem_data_in  in  32  write data from the CPU
- mem_data_out  out  32  read data
- mem_ready  out  1  access complete
- interrupt  out  1  interrupt request to the CPU
- interrupt_ack  in  1  single-cycle acknowledge from the CPU

Behaviour:
- Reset (asynchronous, nreset=0):
  - All registers = 0; prescale counter = 0.
  - mem_ready = 0, mem_data_out = 0, interrupt = 0.
- Register map (word offset):
  - 0 CTRL: bit0 EN, bit1 IE, bit2 AUTO.
  - 1 PRESCALE.
  - 2 RELOAD.
  - 3 COUNT.
  - 4 STATUS: bit0 PEND; write 1 to clear. Remaining bits read 0, writes ignored.
  - Offsets 5-7 read 0 and ignore writes.
  - Registers narrower than 32 bits are zero-extended on read and truncated on write.
- Bus handshake:
  - Access occurs in the cycle where mem_valid=1 and mem_ready=0.
  - In that cycle a write updates the register, or read data is registered into mem_data_out.
  - mem_ready <= mem_valid every cycle: ready rises one cycle after valid and stays high while valid is held.
  - Exactly one access per request; no second write while valid remains high.
  - mem_data_out holds its value until the next access.
- Prescaler:
  - When EN=1, the prescale counter increments each cycle.
  - When it equals PRESCALE, it wraps to 0 and generates a tick. PRESCALE=0 gives a tick every cycle.
  - When EN=0, the prescale counter is held at 0.
- Counter, on a tick:
  - If COUNT != 0: COUNT decrements.
  - If COUNT == 0: PEND <= 1. If AUTO=1, COUNT <= RELOAD. If AUTO=0, EN <= 0 and COUNT stays 0.
- Writing COUNT or PRESCALE resets the prescale counter to 0.
- A CPU write to COUNT in the same cycle as a tick takes priority over the decrement or reload.
- A CPU write to CTRL in the same cycle as a one-shot expiry takes priority over the hardware clear of EN.
- PEND clear sources: interrupt_ack=1 or a STATUS write with bit0=1. If a set and a clear occur in the same cycle, set wins.
- interrupt = PEND & IE, combinational from registers.
- Clearing IE masks interrupt but leaves PEND unchanged.
- Reset mid-access drops mem_ready immediately; the access is abandoned and no register is partially updated.

Optional Feature:
- Macro: TIMER_CAPTURE_EN.
- With the macro defined:
  - Adds input port capture_in (1 bit), passed through a 2-flop synchroniser.
  - A synchronised rising edge latches COUNT into CAPTURE (offset 5, read-only) and sets STATUS bit1 CAPF.
  - CAPF is cleared by writing 1 to STATUS bit1. Set wins over clear in the same cycle.
  - CAPF does not drive interrupt.
- Without the macro: no capture_in port; offset 5 reads 0; STATUS bit1 reads 0.

Test Plan:
- Reset and bus: write 0x1234 to RELOAD with valid held 3 cycles -> mem_ready rises 1 cycle after valid; exactly one write; read of RELOAD returns 0x00001234.
- Periodic: PRESCALE=1, RELOAD=COUNT=3, CTRL=0b111 -> PEND sets on cycle 8 after enable, then every 8 cycles; interrupt high; interrupt_ack pulse clears it the next cycle.
- One-shot: COUNT=2, PRESCALE=0, CTRL=0b011 -> PEND after 3 ticks; CTRL reads 0b010; COUNT stays 0; no further PEND after clear.
- Masking and races: IE=0 with expiry -> PEND=1, interrupt=0; setting IE=1 raises interrupt; STATUS write-1 coinciding with an expiry -> PEND stays 1.
- Mid-run reset: assert nreset low while counting with mem_valid high -> all outputs 0 immediately; after release CTRL=0 and no interrupt.
- Capture (TIMER_CAPTURE_EN): capture_in rises while COUNT=5 -> within 3 cycles CAPTURE reads the COUNT value at the synchronised edge and STATUS reads 0b10.
